// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding and bit-timing helpers (DIV = clocks per bit, HALF = DIV/2)
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;
  function automatic int calc_div(input int clkfreq, input int baud);
    return clkfreq / baud;
  endfunction
  function automatic int calc_half(input int clkfreq, input int baud);
    return calc_div(clkfreq, baud) / 2;
  endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchroniser for an async pin; in clk, rst_n (async low), d; out q (resets to RST_VAL)
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= {2{RST_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver; in clk, rst_n (async low), rx; out data[7:0], valid, frame_err, busy
module uart_rx #(
  parameter int CLKFREQ = 12000000,
  parameter int BAUD    = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  import uart_pkg::*;
  localparam int DIV  = calc_div(CLKFREQ, BAUD);
  localparam int HALF = calc_half(CLKFREQ, BAUD);
  localparam int CW   = $clog2(DIV);
  if (DIV < 4) begin : g_div_chk
    $error("uart_rx: CLKFREQ/BAUD must be at least 4");
  end
  uart_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n, data_n;
  logic valid_n, frame_err_n, rx_s, bit_end;
  uart_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));
  assign bit_end = cnt == CW'(DIV - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
    end
  always_comb begin
    state_n     = state;
    cnt_n       = '0;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    data_n      = data;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: state_n = rx_s ? IDLE : START;
      START: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(HALF - 1)) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_n = cnt + 1'b1;
        if (bit_end) begin
          cnt_n            = '0;
          shift_n[bit_idx] = rx_s;
          bit_idx_n        = bit_idx + 3'd1;
          state_n          = bit_idx == 3'd7 ? STOP : DATA;
        end
      end
      STOP: begin
        cnt_n = cnt + 1'b1;
        if (bit_end) begin
          cnt_n       = '0;
          state_n     = rx_s ? IDLE : BREAK;
          data_n      = rx_s ? shift : data;
          valid_n     = rx_s;
          frame_err_n = !rx_s;
        end
      end
      BREAK: state_n = rx_s ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at DIV=16, HALF=8
module tb_uart_rx;
  typedef struct {
    logic       err;
    logic [7:0] d;
    int         at;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [7:0] data;
  logic valid, frame_err, busy;
  logic pv = 1'b0, pf = 1'b0;
  logic [7:0] last_good = 8'h00;
  int checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  uart_rx #(.CLKFREQ(16), .BAUD(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data),
    .valid(valid), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (valid || frame_err) begin
      check("exclusive", valid & frame_err, 0);
      check("one_cycle", (valid & pv) | (frame_err & pf), 0);
      if (q.size() == 0) check("unexpected_strobe", {valid, frame_err}, 0);
      else begin
        e = q.pop_front();
        check("kind_frame_err", frame_err, e.err);
        check("data", data, e.d);
        if (e.at >= 0) check("strobe_cycle", cyc, e.at);
      end
    end
    pv <= valid;
    pf <= frame_err;
  end
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int pct, input int gap);
    logic [9:0] f;
    exp_t e;
    f = {stop, b, 1'b0};
    e.err = !stop;
    e.d = stop ? b : last_good;
    e.at = (pct == 1600) ? cyc + 155 : -1;
    q.push_back(e);
    if (stop) last_good = b;
    for (int i = 0; i < 10; i++) drive(f[i], ((i + 1) * pct) / 100 - (i * pct) / 100);
    if (gap > 0) drive(1'b1, gap);
  endtask
  initial begin
    logic [7:0] pat [4];
    pat = '{8'h00, 8'hFF, 8'h55, 8'h80};
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    drive(1'b1, 5);
    send(8'hA5, 1'b1, 1600, 20);
    for (int i = 0; i < 4; i++) send(pat[i], 1'b1, 1600, 0);
    drive(1'b1, 20);
    drive(1'b0, 5);
    check("glitch_busy_high", busy, 1);
    drive(1'b1, 6);
    check("glitch_busy_low", busy, 0);
    check("glitch_data", data, last_good);
    drive(1'b1, 20);
    send(8'h3C, 1'b0, 1600, 0);
    drive(1'b0, 40);
    check("break_busy", busy, 1);
    check("break_data", data, last_good);
    drive(1'b1, 6);
    check("break_exit", busy, 0);
    drive(1'b1, 20);
    send(8'h5A, 1'b1, 1600, 20);
    send(8'h12, 1'b1, 1632, 1);
    send(8'h34, 1'b1, 1632, 20);
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b1, 16);
    drive(1'b0, 8);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", data, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", valid, 0);
    check("async_rst_frame_err", frame_err, 0);
    last_good = 8'h00;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 5);
    send(8'h42, 1'b1, 1600, 20);
    drive(1'b1, 40);
    check("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
